// File: rtl/pc_seq_unit_if.sv
// Decoder-to-PC control/status bundle for pc_seq_unit.
interface pc_seq_unit_if #(
  parameter int unsigned D           = 12,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned SDW = $clog2(STACK_DEPTH + 1);

  logic           start;
  logic           done;
  logic           stall;
  logic           reljump_en;
  logic           absjump_en;
  logic           call_en;
  logic           ret_en;
  logic [D-1:0]   offset;
  logic [D-1:0]   target;
  logic [D-1:0]   prog_ctr;
  logic           running;
  logic           halted;
  logic [SDW-1:0] stack_depth;
  logic           stack_ovf;
  logic           stack_unf;

  // Decoder side: drives controls, observes PC and status.
  modport master (
    output start, done, stall, reljump_en, absjump_en, call_en, ret_en,
           offset, target,
    input  prog_ctr, running, halted, stack_depth, stack_ovf, stack_unf
  );

  // PC unit side.
  modport slave (
    input  start, done, stall, reljump_en, absjump_en, call_en, ret_en,
           offset, target,
    output prog_ctr, running, halted, stack_depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Program counter with IDLE/RUN/HALT control, jumps and a return-address stack.
module pc_seq_unit #(
  parameter int unsigned D           = 12,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_VEC   = 0
) (
  input  logic          clk,
  input  logic          reset,
  pc_seq_unit_if.slave  bus
);
  localparam int unsigned SDW = $clog2(STACK_DEPTH + 1);
  localparam logic [D-1:0] RST_PC = D'(RESET_VEC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [SDW-1:0] depth_q, depth_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           running_q, halted_q;
  logic           push_en;
  logic [D-1:0]   push_val;
  logic [D-1:0]   top_val;
  logic [D-1:0]   pc_inc;
  logic           stack_full;
  logic [D-1:0]   stack_q [STACK_DEPTH];

  assign pc_inc     = pc_q + D'(1);
  assign stack_full = (depth_q == SDW'(STACK_DEPTH));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; done always wins over start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.done)       state_d = ST_HALT;
        else if (bus.start) state_d = ST_RUN;
      end
      ST_RUN:  if (bus.done) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Top-of-stack read; only meaningful when depth_q > 0.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (SDW'(i) == depth_q - SDW'(1)) top_val = stack_q[i];
    end
  end

  // Datapath next values: ret > call > absjump > reljump > increment.
  always_comb begin
    pc_d     = pc_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push_en  = 1'b0;
    push_val = pc_inc;
    case (state_q)
      ST_IDLE: pc_d = RST_PC;
      ST_RUN: begin
        if (!bus.done && !bus.stall) begin
          if (bus.ret_en) begin
            if (depth_q != '0) begin
              pc_d    = top_val;
              depth_d = depth_q - SDW'(1);
            end else begin
              pc_d  = pc_inc;
              unf_d = 1'b1;
            end
          end else if (bus.call_en) begin
            pc_d = bus.target;
            if (!stack_full) begin
              push_en = 1'b1;
              depth_d = depth_q + SDW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (bus.absjump_en) begin
            pc_d = bus.target;
          end else if (bus.reljump_en && (bus.offset != '0)) begin
            pc_d = pc_q + bus.offset;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: ;
    endcase
  end

  // PC, depth, sticky flags and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RST_PC;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      running_q <= (state_d == ST_RUN);
      halted_q  <= (state_d == ST_HALT);
    end
  end

  // Stack storage; entries above depth are don't-care so no reset needed.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        if (SDW'(i) == depth_q) stack_q[i] <= push_val;
      end
    end
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.stack_depth = depth_q;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;
endmodule
